// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: arbitrates icache/dcache 256-bit line traffic onto a 4-beat banked memory port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the dcache always wins ties.
module mem_line_arbiter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);
    typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP} state_t;
    state_t state;
    logic [1:0] k, kn;
    logic [LINE_W-1:0] line;
    logic d_req, gnt_d, own_d;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[4:0], d_addr[4:0]};
    assign d_req = d_read | d_write;
    assign kn = k + 2'd1;
    assign i_rdata = line;
    assign d_rdata = line;
`ifdef MEM_ARB_RR_EN
    logic last_d;
    // On a tie the requester that was not granted last goes first.
    assign gnt_d = d_req & (~i_read | ~last_d);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_d <= 1'b1;
        else if (state == IDLE && (i_read || d_req))
            last_d <= gnt_d;
    end
`else
    assign gnt_d = d_req;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            own_d      <= 1'b0;
            line       <= '0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (state)
                IDLE: if (i_read || d_req) begin
                    own_d     <= gnt_d;
                    bmem_addr <= {gnt_d ? d_addr[31:5] : i_addr[31:5], 5'b0};
                    k         <= '0;
                    // A simultaneous d_read/d_write is treated as a write.
                    if (gnt_d && d_write) begin
                        line       <= d_wdata;
                        bmem_write <= 1'b1;
                        bmem_wdata <= d_wdata[BEAT_W-1:0];
                        state      <= WR_DATA;
                    end else begin
                        bmem_read <= 1'b1;
                        state     <= RD_CMD;
                    end
                end
                RD_CMD: if (bmem_ready) begin
                    bmem_read <= 1'b0;
                    state     <= RD_DATA;
                end
                RD_DATA: if (bmem_rvalid) begin
                    line[int'(k)*BEAT_W +: BEAT_W] <= bmem_rdata;
                    k <= kn;
                    if (k == 2'd3) begin
                        state  <= RESP;
                        i_resp <= ~own_d;
                        d_resp <= own_d;
                    end
                end
                WR_DATA: if (bmem_ready) begin
                    k          <= kn;
                    bmem_wdata <= line[int'(kn)*BEAT_W +: BEAT_W];
                    if (k == 2'd3) begin
                        bmem_write <= 1'b0;
                        state      <= RESP;
                        i_resp     <= ~own_d;
                        d_resp     <= own_d;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter: randomized bench with a queue-based requester/memory reference model.
module tb_mem_line_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] i_addr, d_addr, bmem_addr;
    logic i_read, d_read, d_write, i_resp, d_resp;
    logic [255:0] i_rdata, d_rdata, d_wdata;
    logic bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [63:0] bmem_wdata, bmem_rdata;

    always #5 clk = ~clk;

    mem_line_arbiter dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    typedef struct {bit rd; bit wr; logic [31:0] addr; logic [255:0] data;} req_t;
    req_t iq[$], dq[$];
    logic [255:0] mem [logic [31:0]];
    bit last_d;
    int vectors = 0, errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] raddr();
        return 32'h1000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
    endfunction

    // Each requester shows the head of its queue, or nothing.
    task automatic present();
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        if (iq.size() > 0) begin i_read = 1'b1; i_addr = iq[0].addr; end
        if (dq.size() > 0) begin
            d_read = dq[0].rd; d_write = dq[0].wr; d_addr = dq[0].addr; d_wdata = dq[0].data;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iq.delete(); dq.delete(); present();
        bmem_rvalid = 1'b0; bmem_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        last_d = 1'b1;
    endtask

    // Serves every queued request, playing the memory and checking the port against the model.
    task automatic run(input bit rnd, input int first_gap, input int stall_len, input int rst_at,
                       output int lat, output int held1, output logic [3:0] ord);
        bit cur_d, done;
        req_t cur;
        logic [31:0] key;
        logic [255:0] line_v;
        int rb, wb, gap, stalls, n, cmds;
        lat = 0; held1 = 0; ord = '0;
        while (iq.size() > 0 || dq.size() > 0) begin
`ifdef MEM_ARB_RR_EN
            cur_d = dq.size() > 0 && (iq.size() == 0 || !last_d);
`else
            cur_d = dq.size() > 0;
`endif
            cur = cur_d ? dq[0] : iq[0];
            key = cur.addr & 32'hFFFF_FFE0;
            if (!cur.wr && !mem.exists(key)) mem[key] = rand256();
            line_v = cur.wr ? cur.data : mem[key];
            rb = 0; wb = 0; gap = 0; stalls = 0; n = 0; cmds = 0; done = 1'b0;
            while (!done) begin
                @(posedge clk); #1; n++;
                if (n > 80) begin
                    check("timeout", n, 80);
                    do_reset();
                    return;
                end
                bmem_rvalid = 1'b0;
                if (rst_at > 0 && rb == rst_at) begin
                    rst = 1'b1; iq.delete(); dq.delete(); present(); last_d = 1'b1;
                    #1;
                    check("rst_bmem_read", bmem_read, 0);
                    check("rst_resp", {i_resp, d_resp}, 0);
                    @(posedge clk); #1 rst = 1'b0;
                    repeat (4 - rb) begin
                        bmem_rvalid = 1'b1; bmem_rdata = {$urandom, $urandom};
                        @(posedge clk); #1;
                        check("rst_tail_resp", {i_resp, d_resp, bmem_read}, 0);
                    end
                    bmem_rvalid = 1'b0;
                    return;
                end
                bmem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (bmem_write && wb == 1) begin
                    held1++;
                    if (stalls < stall_len) begin bmem_ready = 1'b0; stalls++; end
                end
                if (gap > 0) begin
                    gap--;
                    if (gap == 0) begin
                        bmem_rvalid = 1'b1;
                        bmem_rdata = line_v[rb*64 +: 64];
                        rb++;
                        if (rb < 4) gap = rnd ? $urandom_range(1, 3) : 1;
                    end
                end
                if (bmem_read && bmem_ready) begin
                    check("rd_addr", bmem_addr, key);
                    cmds++;
                    gap = rnd ? $urandom_range(1, 3) : first_gap;
                end
                if (bmem_write) begin
                    if (wb < 4) check("wdata", bmem_wdata, cur.data[wb*64 +: 64]);
                    if (bmem_ready) begin check("wr_addr", bmem_addr, key); wb++; end
                end
                if (i_resp || d_resp) begin
                    check("resp_who", {i_resp, d_resp}, cur_d ? 2'b01 : 2'b10);
                    check("beats", cur.wr ? wb : rb, 4);
                    check("cmds", cmds, cur.wr ? 0 : 1);
                    if (cur.wr) mem[key] = cur.data;
                    else check("rdata", cur_d ? d_rdata : i_rdata, line_v);
                    last_d = cur_d;
                    ord = {ord[2:0], d_resp};
                    if (cur_d) void'(dq.pop_front()); else void'(iq.pop_front());
                    present();
                    lat = n; done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        check("resp_pulse", {i_resp, d_resp}, 0);
    endtask

    initial begin
        int lat, held, ni, nd, op;
        logic [3:0] ord;
        rst = 1'b1; bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_rdata = '0;
        last_d = 1'b1;
        present();
        @(posedge clk); #1;
        check("rst_bmem_read", bmem_read, 0);
        check("rst_bmem_write", bmem_write, 0);
        check("rst_bmem_addr", bmem_addr, 0);
        check("rst_bmem_wdata", bmem_wdata, 0);
        check("rst_resp", {i_resp, d_resp}, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        @(posedge clk); #1 rst = 1'b0;

        iq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1040, data: '0});
        present();
        run(1'b0, 2, 0, 0, lat, held, ord);
        check("rd_latency", lat, 7);

        dq.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'h0000_2000, data: rand256()});
        present();
        run(1'b0, 2, 3, 0, lat, held, ord);
        check("wr_latency", lat, 8);
        check("d1_held", held, 4);
        iq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_2000, data: '0});
        present();
        run(1'b1, 2, 0, 0, lat, held, ord);

        do_reset();
        repeat (2) iq.push_back('{rd: 1'b1, wr: 1'b0, addr: raddr(), data: '0});
        repeat (2) dq.push_back('{rd: 1'b1, wr: 1'b0, addr: raddr(), data: '0});
        present();
        run(1'b1, 2, 0, 0, lat, held, ord);
`ifdef MEM_ARB_RR_EN
        check("tie_order", ord, 4'b0101);
`else
        check("tie_order", ord, 4'b1100);
`endif

        dq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_301F, data: '0});
        present();
        run(1'b0, 2, 0, 0, lat, held, ord);

        iq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1040, data: '0});
        present();
        run(1'b0, 2, 0, 2, lat, held, ord);
        iq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1040, data: '0});
        present();
        run(1'b0, 2, 0, 0, lat, held, ord);
        check("post_rst_latency", lat, 7);

        repeat (5) begin
            bmem_rvalid = 1'b1; bmem_rdata = {$urandom, $urandom};
            @(posedge clk); #1;
            check("stray_rvalid", {i_resp, d_resp, bmem_read, bmem_write}, 0);
        end
        bmem_rvalid = 1'b0;

        repeat (40) begin
            ni = $urandom_range(0, 2);
            nd = $urandom_range(0, 2);
            if (ni + nd == 0) ni = 1;
            repeat (ni) iq.push_back('{rd: 1'b1, wr: 1'b0, addr: raddr(), data: '0});
            repeat (nd) begin
                op = $urandom_range(0, 4);
                dq.push_back('{rd: (op < 2 || op == 4), wr: (op >= 2), addr: raddr(), data: rand256()});
            end
            present();
            run(1'b1, 2, $urandom_range(0, 2), 0, lat, held, ord);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_line_arbiter.md
# mem_line_arbiter

Arbitrates 256-bit cache-line traffic from the instruction cache and data cache onto the single banked memory port (`bmem_*`) and sequences each line into four 64-bit bursts. Sits between the two caches and the banked DRAM model driven by the core's random and directed benches. One transaction is outstanding at a time. Each requester sees a simple request/response line interface.

## Interface
- `LINE_W`, 256, cache-line width in bits; fixed at 4 × `BEAT_W`
- `BEAT_W`, 64, banked memory beat width in bits
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `i_addr`  in  32  icache line address; bits [4:0] ignored
- `i_read`  in  1  icache line read request; held until `i_resp`
- `i_rdata`  out  256  line returned to icache; valid while `i_resp`
- `i_resp`  out  1  one-cycle completion pulse to icache
- `d_addr`  in  32  dcache line address; bits [4:0] ignored
- `d_read`  in  1  dcache line read request; held until `d_resp`
- `d_write`  in  1  dcache line write request; held until `d_resp`
- `d_wdata`  in  256  dcache write line; stable while `d_write`
- `d_rdata`  out  256  line returned to dcache; valid while `d_resp`
- `d_resp`  out  1  one-cycle completion pulse to dcache
- `bmem_addr`  out  32  line-aligned memory address; [4:0] = 0
- `bmem_read`  out  1  read command, one accepted cycle per line
- `bmem_write`  out  1  write beat valid
- `bmem_wdata`  out  64  write beat data
- `bmem_ready`  in  1  memory accepts command or beat this cycle
- `bmem_rdata`  in  64  read beat data
- `bmem_rvalid`  in  1  read beat valid

## Operation
- States: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
- IDLE: if any request is present, latch grantee, address, op and (for writes) `d_wdata`. Go to RD_CMD (read) or WR_DATA (write).
- `d_read` and `d_write` both high is illegal. Write is taken.
- RD_CMD: drive `bmem_read`=1 with `bmem_addr`. Leave to RD_DATA on the cycle `bmem_ready`=1. Otherwise hold.
- RD_DATA: 2-bit beat counter k. Each `bmem_rvalid` writes `bmem_rdata` into line buffer bits [64k+63:64k] and increments k. On beat 3, go to RESP.
- WR_DATA: drive `bmem_write`=1, `bmem_addr`, and `bmem_wdata` = line[64k+63:64k]. k increments only when `bmem_ready`=1. The accepted beat 3 goes to RESP.
- RESP: assert grantee's `*_resp` for exactly one cycle, with `*_rdata` = line buffer for reads. Non-granted `*_resp` stays 0. Next state is IDLE.
- Requester protocol: the requester drops or changes its request at the edge where it samples `*_resp`=1. IDLE therefore always sees a fresh request.
- Line buffer: one 256-bit register shared by reads and writes. `*_rdata` is driven from it and is don't-care outside RESP.
- `bmem_rvalid` outside RD_DATA is ignored.

## Timing
- Reset values: state IDLE, k=0, `bmem_read`=0, `bmem_write`=0, `bmem_addr`=0, `bmem_wdata`=0, `i_resp`=`d_resp`=0, `i_rdata`=`d_rdata`=0, last-grant register = dcache.
- All `bmem_*` and `*_resp` outputs are registered.
- Minimum read latency (ready=1, rvalid on four back-to-back cycles starting 2 cycles after the command): request seen in IDLE at cycle 0 → command at cycle 1 → beats at cycles 3–6 → `resp` at cycle 7.
- Minimum write latency: request at cycle 0 → beats at cycles 1–4 → `resp` at cycle 5.
- `bmem_ready`=0 during WR_DATA stalls the beat. `bmem_wdata` and k hold.
- Gaps between `bmem_rvalid` beats are tolerated.
- Reset asserted mid-burst: immediate return to IDLE and no `resp`. Remaining memory beats are ignored.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin on a tie.
  - The requester not granted last wins.
  - After reset the icache wins the first tie.
  - Last-grant updates on every grant.
- Not defined: fixed priority, dcache always wins ties. The last-grant register is not implemented.

## Test plan
- icache read 0x0000_1040 alone, memory returns beats A0,A1,A2,A3 → one `bmem_read` with addr 0x0000_1040, `i_resp` at cycle 7, `i_rdata` = {A3,A2,A1,A0}.
- dcache write 0x0000_2000, line = {D3,D2,D1,D0}, `bmem_ready` low on the 2nd beat for 3 cycles → beats D0,D1,D2,D3 in order, D1 held 4 cycles, single `d_resp`.
- `i_read` and `d_read` asserted on the same cycle, twice back-to-back → with `MEM_ARB_RR_EN`: icache, dcache, icache, dcache. Without it: both dcache requests are served first.
- `d_addr` = 0x0000_301F → `bmem_addr` = 0x0000_3000.
- `rst` pulsed after the 2nd read beat → no `resp`; the next request starts a clean burst with k=0 and correct data.
- Stray `bmem_rvalid` while IDLE → no state change and no `resp`.
